reg_file_dumper: RTL and testbench

- Read-side companion to the RAT 32x8 register file.
- On command, walks all registers through a spare asynchronous read port (address out, data in, same cycle) and streams each byte out on a valid/ready handshake.
- Appends an XOR checksum byte at the end of each dump.
- Sits between the register file and a debug/UART transmit path. It never writes the register file.

---
 rtl/rat_dbg_pkg.sv | 15 +
 rtl/reg_file_dumper_if.sv | 31 +++
 rtl/reg_file_dumper.sv | 91 +++++++++
 tb/tb_reg_file_dumper.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_dbg_pkg.sv
// rtl/rat_dbg_pkg.sv - shared RAT register file / debug dumper types and default geometry
package rat_dbg_pkg;

   localparam int RAT_NUM_REGS = 32;
   localparam int RAT_ADR_W    = 5;
   localparam int RAT_DATA_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      CSUM  = 2'd3
   } dump_state_t;

endpackage

// File: rtl/reg_file_dumper_if.sv
// rtl/reg_file_dumper_if.sv - byte stream handshake between the dumper and the transmit path
interface reg_file_dumper_if
   import rat_dbg_pkg::*;
#(
   parameter int ADR_W  = RAT_ADR_W,
   parameter int DATA_W = RAT_DATA_W
);

   logic [DATA_W-1:0] DOUT;
   logic [ADR_W-1:0]  DOUT_ADR;
   logic              DOUT_VALID;
   logic              DOUT_READY;
   logic              DOUT_LAST;

   modport master (
      output DOUT,
      output DOUT_ADR,
      output DOUT_VALID,
      output DOUT_LAST,
      input  DOUT_READY
   );

   modport slave (
      input  DOUT,
      input  DOUT_ADR,
      input  DOUT_VALID,
      input  DOUT_LAST,
      output DOUT_READY
   );

endinterface

// File: rtl/reg_file_dumper.sv
// rtl/reg_file_dumper.sv - walks the RAT register file read port and streams every byte plus an XOR checksum
module reg_file_dumper
   import rat_dbg_pkg::*;
#(
   parameter int NUM_REGS = RAT_NUM_REGS,
   parameter int ADR_W    = RAT_ADR_W,
   parameter int DATA_W   = RAT_DATA_W
) (
   input  logic                clk,
   input  logic                RST_N,
   input  logic                START,
   output logic                BUSY,
   output logic                DONE,
   output logic [ADR_W-1:0]    RD_ADR,
   input  logic [DATA_W-1:0]   RD_DATA,
   reg_file_dumper_if.master   dout
);

   localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NUM_REGS - 1);

   dump_state_t       state;
   logic [ADR_W-1:0]  cnt;
   logic [DATA_W-1:0] checksum;
   logic              hs;

   // The read port is asynchronous, so the address must be valid in the same cycle the data is captured.
   assign RD_ADR = cnt;
   assign hs     = dout.DOUT_VALID && dout.DOUT_READY;

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state           <= IDLE;
         cnt             <= '0;
         checksum        <= '0;
         BUSY            <= 1'b0;
         DONE            <= 1'b0;
         dout.DOUT       <= '0;
         dout.DOUT_ADR   <= '0;
         dout.DOUT_VALID <= 1'b0;
         dout.DOUT_LAST  <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  cnt      <= '0;
                  checksum <= '0;
                  BUSY     <= 1'b1;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               dout.DOUT       <= RD_DATA;
               dout.DOUT_ADR   <= cnt;
               dout.DOUT_VALID <= 1'b1;
               dout.DOUT_LAST  <= 1'b0;
               state           <= SEND;
            end
            SEND: begin
               if (hs) begin
                  checksum        <= checksum ^ dout.DOUT;
                  dout.DOUT_VALID <= 1'b0;
                  if (cnt == LAST_ADR) begin
                     state <= CSUM;
                  end else begin
                     cnt   <= cnt + 1'b1;
                     state <= FETCH;
                  end
               end
            end
            CSUM: begin
               // VALID is low on entry (cleared by the last SEND handshake), which marks the load cycle.
               if (!dout.DOUT_VALID) begin
                  dout.DOUT       <= checksum;
                  dout.DOUT_ADR   <= '0;
                  dout.DOUT_LAST  <= 1'b1;
                  dout.DOUT_VALID <= 1'b1;
               end else if (dout.DOUT_READY) begin
                  dout.DOUT_VALID <= 1'b0;
                  dout.DOUT_LAST  <= 1'b0;
                  DONE            <= 1'b1;
                  BUSY            <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_dumper.sv
// tb/tb_reg_file_dumper.sv - scoreboard bench for reg_file_dumper
module tb_reg_file_dumper;
   import rat_dbg_pkg::*;

   typedef struct packed {
      logic [7:0] data;
      logic [4:0] adr;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       RST_N = 1'b0;
   logic       START = 1'b0;
   logic       BUSY;
   logic       DONE;
   logic [4:0] RD_ADR;
   logic [7:0] RD_DATA;
   logic [7:0] rf [32];
   logic [7:0] exp_rf [32];

   beat_t exp_q [$];
   int    n_pass = 0;
   int    n_total = 0;
   int    n_bytes = 0;
   int    n_done = 0;

   logic       rdy_toggle = 1'b0;
   logic [7:0] rdy_pat = 8'b0101_1001;
   int         rdy_idx = 0;

   reg_file_dumper_if dout_if ();

   reg_file_dumper dut (
      .clk     (clk),
      .RST_N   (RST_N),
      .START   (START),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .RD_ADR  (RD_ADR),
      .RD_DATA (RD_DATA),
      .dout    (dout_if.master)
   );

   assign RD_DATA = rf[RD_ADR];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
   endtask

   initial begin
      dout_if.DOUT_READY = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_toggle) begin
            dout_if.DOUT_READY = rdy_pat[rdy_idx % 8];
            rdy_idx++;
         end else begin
            dout_if.DOUT_READY = 1'b1;
         end
      end
   end

   // Monitor: a beat seen valid&&ready at the falling edge is accepted on the next rising edge.
   initial begin
      beat_t cur, prev_beat, e;
      logic  prev_valid, prev_hs, prev_done;
      prev_valid = 1'b0; prev_hs = 1'b0; prev_done = 1'b0; prev_beat = '0;
      forever begin
         @(negedge clk);
         cur = {dout_if.DOUT, dout_if.DOUT_ADR, dout_if.DOUT_LAST};
         if (RST_N) begin
            if (dout_if.DOUT_VALID && prev_valid && !prev_hs)
               check("stall_hold", 32'(cur), 32'(prev_beat));
            if (dout_if.DOUT_VALID && dout_if.DOUT_READY) begin
               check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check($sformatf("beat_adr%0d_last%0d", e.adr, e.last), 32'(cur), 32'(e));
               end
               n_bytes++;
            end
            if (DONE) begin
               check("done_single_cycle", 32'(prev_done), 32'd0);
               n_done++;
            end
            prev_valid = dout_if.DOUT_VALID;
            prev_hs    = dout_if.DOUT_VALID && dout_if.DOUT_READY;
            prev_done  = DONE;
            prev_beat  = cur;
         end else begin
            prev_valid = 1'b0; prev_hs = 1'b0; prev_done = 1'b0;
         end
      end
   end

   task automatic load_ramp();
      for (int i = 0; i < 32; i++) begin
         rf[i] = 8'(i);
         exp_rf[i] = 8'(i);
      end
   endtask

   task automatic load_a5();
      for (int i = 0; i < 32; i++) begin
         rf[i] = 8'h00;
         exp_rf[i] = 8'h00;
      end
      rf[0] = 8'hA5;
      exp_rf[0] = 8'hA5;
   endtask

   task automatic push_dump(input logic [7:0] csum);
      beat_t b;
      for (int i = 0; i < 32; i++) begin
         b.data = exp_rf[i]; b.adr = 5'(i); b.last = 1'b0;
         exp_q.push_back(b);
      end
      b.data = csum; b.adr = 5'd0; b.last = 1'b1;
      exp_q.push_back(b);
   endtask

   task automatic pulse_start(output time t_acc);
      @(posedge clk);
      #1 START = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1 START = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (DONE) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_valid_adr(input logic [4:0] a, input int bound);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (dout_if.DOUT_VALID && dout_if.DOUT_ADR == a) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("reach_adr%0d", a), 32'(ok), 32'd1);
   endtask

   task automatic full_dump(input logic [7:0] csum, input string tag);
      time t0;
      push_dump(csum);
      pulse_start(t0);
      @(negedge clk);
      check({tag, "_busy_high"}, 32'(BUSY), 32'd1);
      wait_done(200);
      check({tag, "_done_latency"}, 32'($time - t0), 32'd665);
      check({tag, "_busy_low_at_done"}, 32'(BUSY), 32'd0);
      @(negedge clk);
      check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int  nb, nd;
      bit  ok;
      time t0;

      load_ramp();
      #12;
      check("reset_outputs", 32'({BUSY, DONE, RD_ADR, dout_if.DOUT, dout_if.DOUT_ADR,
                                  dout_if.DOUT_VALID, dout_if.DOUT_LAST}), 32'd0);
      #1 RST_N = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp file: bytes 0x00..0x1F, XOR of 0..31 is 0x00.
      load_ramp();
      full_dump(8'h00, "ramp");

      load_a5();
      full_dump(8'hA5, "single_a5");

      // Same file with a stalling sink.
      load_a5();
      push_dump(8'hA5);
      rdy_toggle = 1'b1;
      pulse_start(t0);
      wait_done(1000);
      rdy_toggle = 1'b0;
      @(negedge clk);
      check("stall_queue_drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset while DOUT_ADR=10.
      load_ramp();
      push_dump(8'h00);
      pulse_start(t0);
      wait_valid_adr(5'd10, 100);
      #2 RST_N = 1'b0;
      #1;
      check("async_reset_outputs", 32'({BUSY, DONE, RD_ADR, dout_if.DOUT, dout_if.DOUT_ADR,
                                        dout_if.DOUT_VALID, dout_if.DOUT_LAST}), 32'd0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_done_in_reset", 32'(DONE), 32'd0);
      end
      @(posedge clk);
      #3 RST_N = 1'b1;
      repeat (2) @(negedge clk);
      full_dump(8'h00, "after_reset");

      // START while busy at address 5 is ignored.
      load_ramp();
      push_dump(8'h00);
      nb = n_bytes;
      nd = n_done;
      pulse_start(t0);
      wait_valid_adr(5'd5, 100);
      @(posedge clk);
      #1 START = 1'b1;
      @(posedge clk);
      #1 START = 1'b0;
      wait_done(200);
      check("busy_start_latency", 32'($time - t0), 32'd665);
      repeat (10) @(negedge clk);
      check("busy_start_bytes", 32'(n_bytes - nb), 32'd33);
      check("busy_start_dones", 32'(n_done - nd), 32'd1);
      check("busy_start_idle", 32'(BUSY), 32'd0);

      // Write reg[20]=0x3C at address 3's FETCH: checksum 0x14^0x3C = 0x28.
      load_ramp();
      exp_rf[20] = 8'h3C;
      push_dump(8'h28);
      pulse_start(t0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (BUSY && RD_ADR == 5'd3 && !dout_if.DOUT_VALID) begin
            ok = 1'b1;
            break;
         end
      end
      check("reach_fetch3", 32'(ok), 32'd1);
      rf[20] = 8'h3C;
      wait_done(200);
      @(negedge clk);
      check("rf_write_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
